// File: rtl/platform_pkg.sv
// Platform-wide constants and types shared by the UART transmit path.
package platform_pkg;

  // Default bit period: 83.33 MHz system clock, 115200 baud.
  localparam int CLKS_PER_BAUD = 723;

  // 8N1 framing: eight data bits per character.
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth and a combinational head read,
// so a consumer can take the head byte on the same edge it pops.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_POT  = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_POT:0]    count_o
);

  localparam int DEPTH = 1 << DEPTH_POT;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_POT-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_POT-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_POT:0]    count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  // Count never exceeds DEPTH, so its top bit alone marks a full FIFO.
  assign full_o  = count_q[DEPTH_POT];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Guard push/pop against full/empty; pointers wrap naturally at DEPTH.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a FIFO; back-to-back frames with no idle gap.
module uart_tx_buffered
  import platform_pkg::*;
#(
  parameter int CLKS_PER_BAUD  = platform_pkg::CLKS_PER_BAUD,
  parameter int FIFO_DEPTH_POT = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [7:0]                data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic                      uart_tx_o,
  output logic                      busy_o,
  output logic [FIFO_DEPTH_POT:0]   fifo_count_o
);

  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BAUD - 1);
  localparam logic [2:0]  LAST_BIT    = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q, state_d;
  logic [15:0]               baud_cnt_q, baud_cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;

  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_head;
  logic                      baud_done;

  sync_fifo #(
    .DATA_WIDTH (UART_DATA_BITS),
    .DEPTH_POT  (FIFO_DEPTH_POT)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (data_i),
    .push_i  (valid_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign ready_o   = !fifo_full;
  assign uart_tx_o = tx_q;
  assign busy_o    = (state_q != IDLE);
  assign baud_done = (baud_cnt_q == '0);

  // Next-state logic: each bit lasts BAUD_RELOAD+1 cycles; a waiting byte is
  // popped straight into START either from IDLE or at the end of STOP.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_done ? baud_cnt_q : baud_cnt_q - 16'd1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_head;
          baud_cnt_d = BAUD_RELOAD;
          tx_d       = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_cnt_d = BAUD_RELOAD;
          bit_idx_d  = '0;
          tx_d       = shift_q[0];
          state_d    = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_d = BAUD_RELOAD;
          if (bit_idx_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_d    = fifo_head;
            baud_cnt_d = BAUD_RELOAD;
            tx_d       = 1'b0;
            state_d    = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and the registered serial output.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: queue-based line model, loopback receiver,
// directed frame/flow-control/reset scenarios and a randomized soak.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int POT   = 4;
  localparam int DEPTH = 1 << POT;
  localparam int FRAME = 10 * CPB;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   data;
  logic         valid;
  logic         ready;
  logic         tx;
  logic         busy;
  logic [POT:0] count;

  int checks = 0;
  int errors = 0;

  // Behavioural model: queued bytes plus the frame on the line and its age.
  logic [7:0] m_q[$];
  logic [7:0] log_q[$];
  logic [7:0] rx_log[$];
  logic [7:0] m_cur;
  bit         m_active;
  int         m_off;
  bit         m_acc;

  // Loopback receiver state.
  bit         rx_busy;
  int         rx_cnt;
  logic [7:0] rx_byte;

  uart_tx_buffered #(
    .CLKS_PER_BAUD  (CPB),
    .FIFO_DEPTH_POT (POT)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .data_i       (data),
    .valid_i      (valid),
    .ready_o      (ready),
    .uart_tx_o    (tx),
    .busy_o       (busy),
    .fifo_count_o (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Line level of an 8N1 frame 'off' cycles after its start bit began.
  function automatic logic frame_level(input logic [7:0] b, input int off);
    int idx;
    idx = off / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  function automatic logic exp_tx();
    if (!m_active) return 1'b1;
    return frame_level(m_cur, m_off);
  endfunction

  // Model step: finished frame releases the line, a waiting byte starts at
  // once, then the accepted byte (if any) joins the queue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      log_q.delete();
      m_active = 1'b0;
      m_off    = 0;
    end else begin
      m_acc = valid && (m_q.size() < DEPTH);
      if (m_active) begin
        m_off++;
        if (m_off == FRAME) m_active = 1'b0;
      end
      if (!m_active && m_q.size() > 0) begin
        m_cur    = m_q.pop_front();
        log_q.push_back(m_cur);
        m_active = 1'b1;
        m_off    = 0;
      end
      if (m_acc) m_q.push_back(data);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("tx", tx, exp_tx());
    chk("busy", busy, m_active);
    chk("count", count, m_q.size());
    chk("ready", ready, m_q.size() < DEPTH);
  end

  // Loopback receiver sampling mid-bit; checks stop bit and byte order.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      rx_busy = 1'b0;
      rx_cnt  = 0;
    end else if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % CPB) == CPB/2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
        rx_byte[rx_cnt/CPB - 1] = tx;
      if (rx_cnt == FRAME - CPB/2) begin
        chk("rx_stop_bit", tx, 1'b1);
        if (log_q.size() > 0) chk("rx_byte", rx_byte, log_q.pop_front());
        else chk("rx_pending", log_q.size(), 1);
        rx_log.push_back(rx_byte);
        $display("rx byte %02h t=%0t", rx_byte, $time);
        rx_busy = 1'b0;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Called 2 time units after an edge; holds valid until accepted.
  task automatic push_byte(input logic [7:0] b);
    bit done;
    done  = 1'b0;
    valid = 1'b1;
    data  = b;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (ready) done = 1'b1;
      @(posedge clk);
      #2;
    end
    valid = 1'b0;
    chk("push_accepted", done, 1'b1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 5000 && (busy || count != 0); i++) wait_cycles(1);
    chk("idle_reached", busy || count != 0, 1'b0);
  endtask

  // Called 2 units after the edge that accepted the first byte; checks the
  // exact line pattern (one character per bit) from the following edge.
  task automatic expect_line(input string pat);
    @(posedge clk);
    #2;
    valid = 1'b0;
    for (int i = 0; i < pat.len() * CPB; i++) begin
      @(negedge clk);
      chk("line_bit", tx, pat[i/CPB] == "1");
      chk("line_busy", busy, 1'b1);
    end
    @(negedge clk);
    chk("line_end_busy", busy, 1'b0);
    chk("line_end_tx", tx, 1'b1);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_ready", ready, 1'b1);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(1);
  endtask

  initial begin
    int acc;
    int dens;
    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    #1;
    chk("init_tx", tx, 1'b1);
    chk("init_busy", busy, 1'b0);
    chk("init_count", count, 0);
    chk("init_ready", ready, 1'b1);
    @(posedge clk);
    #2;
    do_reset();

    // Single byte 0x55: alternating line, start bit one cycle after accept.
    push_byte(8'h55);
    expect_line("0101010101");

    // Two bytes on consecutive cycles: contiguous 80-cycle burst.
    wait_idle();
    valid = 1'b1;
    data  = 8'hA5;
    @(posedge clk);
    #2;
    data = 8'h3C;
    expect_line("01010010110001111001");

    // Hold valid for 20 cycles: 17 accepted, FIFO full at 16.
    wait_idle();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      valid = 1'b1;
      data  = 8'($urandom);
      if (ready) acc++;
      @(posedge clk);
      #2;
    end
    valid = 1'b0;
    chk("burst_accepted", acc, 17);
    chk("burst_count", count, 16);
    chk("burst_ready", ready, 1'b0);
    for (int i = 0; i < 100 && !ready; i++) wait_cycles(1);
    chk("ready_return", ready, 1'b1);
    chk("count_after_pop", count, 15);
    wait_idle();

    // "Hi\n" through the loopback receiver.
    wait_cycles(2);
    rx_log.delete();
    push_byte(8'h48);
    push_byte(8'h69);
    push_byte(8'h0A);
    wait_idle();
    chk("hi_len", rx_log.size(), 3);
    if (rx_log.size() == 3) begin
      chk("hi_0", rx_log[0], 8'h48);
      chk("hi_1", rx_log[1], 8'h69);
      chk("hi_2", rx_log[2], 8'h0A);
    end

    // Push and pop on the same edge with five bytes waiting.
    wait_cycles(2);
    rx_log.delete();
    for (int i = 0; i < 6; i++) push_byte(8'h10 + 8'(i));
    chk("pp_pre_count", count, 5);
    for (int i = 0; i < 200 && !(m_active && m_off == FRAME - 1); i++) wait_cycles(1);
    chk("pp_reach_end", m_off, FRAME - 1);
    valid = 1'b1;
    data  = 8'h16;
    @(posedge clk);
    #2;
    valid = 1'b0;
    chk("pp_count", count, 5);
    wait_idle();
    chk("pp_len", rx_log.size(), 7);
    for (int i = 0; i < rx_log.size() && i < 7; i++)
      chk("pp_order", rx_log[i], 8'h10 + 8'(i));

    // Reset during bit 3 of the first of three queued frames.
    wait_cycles(2);
    push_byte(8'hFF);
    push_byte(8'h00);
    push_byte(8'h81);
    for (int i = 0; i < 200 && !(m_active && m_off == 17); i++) wait_cycles(1);
    chk("bit3_reached", m_off, 17);
    do_reset();
    wait_cycles(50);
    chk("post_rst_count", count, 0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_tx", tx, 1'b1);

    // Randomized soak with varying push density and one mid-run reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case ((cyc / 500) % 3)
        0:       dens = 5;
        1:       dens = 30;
        default: dens = 90;
      endcase
      valid = ($urandom_range(0, 99) < dens);
      data  = 8'($urandom);
      if (cyc == 1700) begin
        valid = 1'b0;
        do_reset();
      end else begin
        wait_cycles(1);
      end
    end
    valid = 1'b0;
    wait_idle();
    wait_cycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
